// File: rtl/arb_mon_pkg.sv
// rtl/arb_mon_pkg.sv - shared types and helpers for the arbiter performance monitor
package arb_mon_pkg;

    typedef enum logic [1:0] {
        IDLE    = 2'd0,
        WAIT    = 2'd1,
        GRANTED = 2'd2
    } chan_state_e;

    // Width of a channel index; never less than one bit.
    function automatic int unsigned chan_idx_w(input int unsigned n);
        return (n > 1) ? $clog2(n) : 1;
    endfunction

    // Increment that holds at max_v instead of wrapping.
    function automatic logic [31:0] sat_inc(input logic [31:0] v, input logic [31:0] max_v);
        return (v >= max_v) ? max_v : v + 32'd1;
    endfunction

endpackage

// File: rtl/arb_mon_chan.sv
// rtl/arb_mon_chan.sv - per-channel latency FSM, error detect and grant counter
module arb_mon_chan
    import arb_mon_pkg::*;
#(
    parameter int LAT_W    = 8,
    parameter int MAX_WAIT = 16,
    parameter int CNT_W    = 16
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             req,
    input  logic             gnt,
    input  logic             clr_err,
    output logic             rpt_valid,
    output logic [LAT_W-1:0] rpt_cycles,
    output logic             err_spurious,
    output logic             err_starve,
    output logic [CNT_W-1:0] grant_count
);

    localparam logic [31:0] LAT_MAX = 32'((64'd1 << LAT_W) - 64'd1);
    localparam logic [31:0] CNT_MAX = 32'((64'd1 << CNT_W) - 64'd1);

    chan_state_e      state, state_nxt;
    logic [LAT_W-1:0] wait_cnt, wait_nxt;
    logic             starve_hit;
    logic             gnt_prev;

    // State and wait counter registers
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state    <= IDLE;
            wait_cnt <= '0;
        end else begin
            state    <= state_nxt;
            wait_cnt <= wait_nxt;
        end
    end

    // Next-state logic; a report is raised on the sample that completes a measurement
    always_comb begin
        state_nxt  = state;
        wait_nxt   = wait_cnt;
        rpt_valid  = 1'b0;
        rpt_cycles = '0;
        starve_hit = 1'b0;
        case (state)
            IDLE: begin
                if (req && gnt) begin
                    state_nxt = GRANTED;
                    rpt_valid = 1'b1;
                end else if (req) begin
                    state_nxt = WAIT;
                    wait_nxt  = LAT_W'(1);
                end
            end
            WAIT: begin
                if (gnt) begin
                    state_nxt  = GRANTED;
                    rpt_valid  = 1'b1;
                    rpt_cycles = wait_cnt;
                    wait_nxt   = '0;
                end else if (!req) begin
                    state_nxt = IDLE;
                    wait_nxt  = '0;
                end else begin
                    starve_hit = (32'(wait_cnt) == 32'(MAX_WAIT));
                    wait_nxt   = LAT_W'(sat_inc(32'(wait_cnt), LAT_MAX));
                end
            end
            GRANTED: begin
                if (!gnt) begin
                    state_nxt = req ? WAIT : IDLE;
                    wait_nxt  = req ? LAT_W'(1) : '0;
                end
            end
            default: begin
                state_nxt = IDLE;
                wait_nxt  = '0;
            end
        endcase
    end

    // Sticky error flags; a fresh error wins over a simultaneous clear
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            err_spurious <= 1'b0;
            err_starve   <= 1'b0;
        end else begin
            err_spurious <= (err_spurious & ~clr_err) | (gnt & ~req);
            err_starve   <= (err_starve & ~clr_err) | starve_hit;
        end
    end

    // Saturating count of grant rising samples
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            gnt_prev    <= 1'b0;
            grant_count <= '0;
        end else begin
            gnt_prev <= gnt;
            if (gnt && !gnt_prev) begin
                grant_count <= CNT_W'(sat_inc(32'(grant_count), CNT_MAX));
            end
        end
    end

endmodule

// File: rtl/arbiter_perf_monitor.sv
// rtl/arbiter_perf_monitor.sv - passive N-channel arbiter latency and protocol monitor
module arbiter_perf_monitor
    import arb_mon_pkg::*;
#(
    parameter int N_CHAN   = 2,
    parameter int LAT_W    = 8,
    parameter int MAX_WAIT = 16,
    parameter int CNT_W    = 16
) (
    input  logic                      clk,
    input  logic                      rst,
    input  logic [N_CHAN-1:0]         request,
    input  logic [N_CHAN-1:0]         grant,
    input  logic                      clr_err,
    output logic                      lat_valid,
    output logic [$clog2(N_CHAN)-1:0] lat_chan,
    output logic [LAT_W-1:0]          lat_cycles,
    output logic                      lat_dropped,
    output logic                      err_multi_grant,
    output logic [N_CHAN-1:0]         err_spurious,
    output logic [N_CHAN-1:0]         err_starve,
    output logic [N_CHAN*CNT_W-1:0]   grant_count
);

    localparam int CHAN_IDX_W = chan_idx_w(N_CHAN);

    logic [N_CHAN-1:0]     rpt_valid;
    logic [LAT_W-1:0]      rpt_cycles [N_CHAN];
    logic                  sel_valid;
    logic                  sel_dropped;
    logic [CHAN_IDX_W-1:0] sel_idx;
    logic [LAT_W-1:0]      sel_cycles;

    for (genvar g = 0; g < N_CHAN; g++) begin : g_chan
        arb_mon_chan #(
            .LAT_W    (LAT_W),
            .MAX_WAIT (MAX_WAIT),
            .CNT_W    (CNT_W)
        ) u_chan (
            .clk          (clk),
            .rst          (rst),
            .req          (request[g]),
            .gnt          (grant[g]),
            .clr_err      (clr_err),
            .rpt_valid    (rpt_valid[g]),
            .rpt_cycles   (rpt_cycles[g]),
            .err_spurious (err_spurious[g]),
            .err_starve   (err_starve[g]),
            .grant_count  (grant_count[g*CNT_W +: CNT_W])
        );
    end

    // Lowest-index report wins; any other simultaneous report is counted as dropped
    always_comb begin
        sel_valid   = 1'b0;
        sel_dropped = 1'b0;
        sel_idx     = '0;
        sel_cycles  = '0;
        for (int i = 0; i < N_CHAN; i++) begin
            if (rpt_valid[i]) begin
                if (!sel_valid) begin
                    sel_valid  = 1'b1;
                    sel_idx    = CHAN_IDX_W'(i);
                    sel_cycles = rpt_cycles[i];
                end else begin
                    sel_dropped = 1'b1;
                end
            end
        end
    end

    // Registered latency report and sticky multi-grant flag
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            lat_valid       <= 1'b0;
            lat_chan        <= '0;
            lat_cycles      <= '0;
            lat_dropped     <= 1'b0;
            err_multi_grant <= 1'b0;
        end else begin
            lat_valid       <= sel_valid;
            lat_chan        <= sel_idx;
            lat_cycles      <= sel_cycles;
            lat_dropped     <= sel_dropped;
            err_multi_grant <= (err_multi_grant & ~clr_err) | ($countones(grant) > 1);
        end
    end

endmodule

// File: tb/tb_arbiter_perf_monitor.sv
// tb/tb_arbiter_perf_monitor.sv - self-checking bench for arbiter_perf_monitor
module tb_arbiter_perf_monitor;

    localparam int N  = 2;
    localparam int LW = 8;
    localparam int MW = 16;
    localparam int CW = 16;
    localparam int LAT_SAT = (1 << LW) - 1;
    localparam int CNT_SAT = (1 << CW) - 1;

    logic            clk = 1'b0;
    logic            rst = 1'b1;
    logic [N-1:0]    request = '0;
    logic [N-1:0]    grant = '0;
    logic            clr_err = 1'b0;
    logic            lat_valid;
    logic [0:0]      lat_chan;
    logic [LW-1:0]   lat_cycles;
    logic            lat_dropped;
    logic            err_multi_grant;
    logic [N-1:0]    err_spurious;
    logic [N-1:0]    err_starve;
    logic [N*CW-1:0] grant_count;

    arbiter_perf_monitor #(
        .N_CHAN   (N),
        .LAT_W    (LW),
        .MAX_WAIT (MW),
        .CNT_W    (CW)
    ) dut (
        .clk             (clk),
        .rst             (rst),
        .request         (request),
        .grant           (grant),
        .clr_err         (clr_err),
        .lat_valid       (lat_valid),
        .lat_chan        (lat_chan),
        .lat_cycles      (lat_cycles),
        .lat_dropped     (lat_dropped),
        .err_multi_grant (err_multi_grant),
        .err_spurious    (err_spurious),
        .err_starve      (err_starve),
        .grant_count     (grant_count)
    );

    always #5 clk = ~clk;

    int n_vec = 0;
    int n_bad = 0;

    // Reference model: a pending request is remembered by the sample index at which
    // its wait began; latency is the distance in samples to the granting sample.
    int t;
    int m_start [N];
    bit m_hold  [N];
    bit m_pg    [N];
    int m_cnt   [N];
    bit m_spur  [N];
    bit m_starve[N];
    bit m_multi;
    bit e_valid;
    bit e_drop;
    int e_chan;
    int e_cyc;

    task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        assert (obs === exp) else begin
            n_bad++;
            $error("FAIL %s: observed %0d expected %0d", tag, obs, exp);
        end
    endtask

    task automatic model_reset();
        t = 0;
        for (int i = 0; i < N; i++) begin
            m_start[i]  = -1;
            m_hold[i]   = 1'b0;
            m_pg[i]     = 1'b0;
            m_cnt[i]    = 0;
            m_spur[i]   = 1'b0;
            m_starve[i] = 1'b0;
        end
        m_multi = 1'b0;
        e_valid = 1'b0;
        e_drop  = 1'b0;
        e_chan  = 0;
        e_cyc   = 0;
    endtask

    task automatic model_sample(input logic [N-1:0] r, input logic [N-1:0] g, input logic c);
        int nrep = 0;
        e_valid = 1'b0;
        e_drop  = 1'b0;
        for (int i = 0; i < N; i++) begin
            bit rep = 1'b0;
            int lat = 0;
            bit st  = 1'b0;
            if (m_start[i] >= 0) begin
                if (g[i]) begin
                    rep        = 1'b1;
                    lat        = (t - m_start[i] > LAT_SAT) ? LAT_SAT : t - m_start[i];
                    m_start[i] = -1;
                    m_hold[i]  = 1'b1;
                end else if (!r[i]) begin
                    m_start[i] = -1;
                end else if (t - m_start[i] == MW) begin
                    st = 1'b1;
                end
            end else if (m_hold[i]) begin
                if (!g[i]) begin
                    m_hold[i] = 1'b0;
                    if (r[i]) m_start[i] = t;
                end
            end else begin
                if (r[i] && g[i]) begin
                    rep       = 1'b1;
                    m_hold[i] = 1'b1;
                end else if (r[i]) begin
                    m_start[i] = t;
                end
            end
            if (rep) begin
                nrep++;
                if (nrep == 1) begin
                    e_valid = 1'b1;
                    e_chan  = i;
                    e_cyc   = lat;
                end else begin
                    e_drop = 1'b1;
                end
            end
            if (g[i] && !m_pg[i]) m_cnt[i] = (m_cnt[i] >= CNT_SAT) ? CNT_SAT : m_cnt[i] + 1;
            m_pg[i]     = g[i];
            m_spur[i]   = (m_spur[i] & !c) | (g[i] & !r[i]);
            m_starve[i] = (m_starve[i] & !c) | st;
        end
        m_multi = (m_multi & !c) | ($countones(g) > 1);
        t++;
    endtask

    task automatic check_outputs(input string where);
        check({where, ".lat_valid"}, lat_valid, e_valid);
        if (e_valid) begin
            check({where, ".lat_chan"}, lat_chan, e_chan);
            check({where, ".lat_cycles"}, lat_cycles, e_cyc);
        end
        check({where, ".lat_dropped"}, lat_dropped, e_drop);
        check({where, ".err_multi_grant"}, err_multi_grant, m_multi);
        for (int i = 0; i < N; i++) begin
            check($sformatf("%s.err_spurious[%0d]", where, i), err_spurious[i], m_spur[i]);
            check($sformatf("%s.err_starve[%0d]", where, i), err_starve[i], m_starve[i]);
            check($sformatf("%s.grant_count[%0d]", where, i), grant_count[i*CW +: CW], m_cnt[i]);
        end
    endtask

    task automatic step(input string where, input logic [N-1:0] r, input logic [N-1:0] g, input logic c);
        request = r;
        grant   = g;
        clr_err = c;
        model_sample(r, g, c);
        @(posedge clk);
        #1;
        n_vec++;
        check_outputs(where);
    endtask

    initial begin
        logic [N-1:0] r;
        logic [N-1:0] g;
        int sel;

        model_reset();
        #2;
        check_outputs("reset");
        @(posedge clk);
        #1;
        rst = 1'b0;

        // Latency 3: request at sample 10, grant at sample 13
        for (int i = 0; i < 10; i++) step("idle", 2'b00, 2'b00, 1'b0);
        step("t1_req", 2'b01, 2'b00, 1'b0);
        step("t1_w", 2'b01, 2'b00, 1'b0);
        step("t1_w", 2'b01, 2'b00, 1'b0);
        step("t1_gnt", 2'b01, 2'b01, 1'b0);
        check("t1_lat_valid", lat_valid, 1);
        check("t1_lat_cycles", lat_cycles, 3);
        check("t1_grant_count0", grant_count[CW-1:0], 1);
        step("t1_rel", 2'b00, 2'b00, 1'b0);

        // Request and grant together on channel 1: latency 0
        step("t2_gnt", 2'b10, 2'b10, 1'b0);
        check("t2_lat_chan", lat_chan, 1);
        check("t2_lat_cycles", lat_cycles, 0);
        step("t2_rel", 2'b00, 2'b00, 1'b0);

        // Starvation at wait 16, grant at wait 20, then clear
        step("t3_req", 2'b01, 2'b00, 1'b0);
        for (int j = 1; j < 20; j++) begin
            step("t3_w", 2'b01, 2'b00, 1'b0);
            if (j == 15) check("t3_starve_pre", err_starve[0], 0);
            if (j == 16) check("t3_starve_set", err_starve[0], 1);
        end
        step("t3_gnt", 2'b01, 2'b01, 1'b0);
        check("t3_lat_cycles", lat_cycles, 20);
        step("t3_clr", 2'b00, 2'b00, 1'b1);
        check("t3_starve_clr", err_starve[0], 0);

        // Double grant: multi-grant flag, channel 0 reported, drop pulse
        step("t4_req", 2'b11, 2'b00, 1'b0);
        step("t4_gnt", 2'b11, 2'b11, 1'b0);
        check("t4_multi", err_multi_grant, 1);
        check("t4_lat_chan", lat_chan, 0);
        check("t4_lat_cycles", lat_cycles, 1);
        check("t4_dropped", lat_dropped, 1);
        step("t4_rel", 2'b00, 2'b00, 1'b0);

        // Spurious grant with a simultaneous clear: set wins
        step("t5_spur", 2'b00, 2'b10, 1'b1);
        check("t5_spur1", err_spurious[1], 1);
        check("t5_multi_clr", err_multi_grant, 0);
        step("t5_rel", 2'b00, 2'b00, 1'b0);

        // Asynchronous reset while channel 0 waits at wait=5
        step("t6_req", 2'b01, 2'b00, 1'b0);
        for (int j = 0; j < 4; j++) step("t6_w", 2'b01, 2'b00, 1'b0);
        rst = 1'b1;
        model_reset();
        #1;
        check_outputs("t6_rst");
        check("t6_rst_spur", err_spurious, 0);
        check("t6_rst_count", grant_count, 0);
        #1;
        rst = 1'b0;
        for (int j = 0; j < 3; j++) begin
            step("t6_quiet", 2'b00, 2'b00, 1'b0);
            check("t6_no_report", lat_valid, 0);
        end
        step("t6_fresh", 2'b01, 2'b00, 1'b0);
        step("t6_gnt", 2'b01, 2'b01, 1'b0);
        check("t6_lat_cycles", lat_cycles, 1);

        // Randomized traffic: busy phase, then a sparse-grant phase to reach starvation
        r = '0;
        for (int k = 0; k < 600; k++) begin
            if (k < 300) begin
                r = r ^ {N'($urandom_range(0, 3) == 0), N'($urandom_range(0, 3) == 0)} & {1'b1, 1'b1};
                r[1] = r[1] ^ ($urandom_range(0, 3) == 0);
                r[0] = r[0] ^ ($urandom_range(0, 3) == 0);
                sel = int'($urandom_range(0, 9));
                case (sel)
                    5:       g = 2'b01;
                    6:       g = 2'b10;
                    7:       g = r & 2'b01;
                    8:       g = r & 2'b10;
                    9:       g = 2'($urandom_range(0, 3));
                    default: g = 2'b00;
                endcase
            end else begin
                if ($urandom_range(0, 29) == 0) r[0] = ~r[0];
                if ($urandom_range(0, 29) == 0) r[1] = ~r[1];
                sel = int'($urandom_range(0, 24));
                g = (sel == 0) ? (r & 2'b01) : (sel == 1) ? (r & 2'b10) : 2'b00;
            end
            step("rand", r, g, $urandom_range(0, 15) == 0);
        end

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
        $finish;
    end

endmodule

// File: doc/arbiter_perf_monitor.md
Name: arbiter_perf_monitor

Overview:
- Clocked, parametrised successor to the two-channel edge-triggered arbiter monitor.
- Passively observes N request/grant pairs on the arbiter interface (MONITOR modport) and measures request-to-grant latency per channel.
- Flags protocol violations (multiple grants, spurious grant, starvation) and keeps per-channel grant counts.
- Sits alongside the arbiter in the testbench/top; drives nothing onto the interface.

Parameters:
- N_CHAN, 2, number of request/grant channels (2..16)
- LAT_W, 8, latency counter width in cycles; saturating
- MAX_WAIT, 16, wait cycles after which a pending request is flagged starved; must be < 2**LAT_W
- CNT_W, 16, per-channel grant counter width; saturating

Ports:
- clk  input  1  single clock; all sampling on posedge
- rst  input  1  asynchronous, active-high reset
- request  input  N_CHAN  request vector from the interface
- grant  input  N_CHAN  grant vector from the interface
- clr_err  input  1  synchronous clear of all sticky error flags
- lat_valid  output  1  one-cycle pulse: latency sample reported
- lat_chan  output  $clog2(N_CHAN)  channel index of the reported sample
- lat_cycles  output  LAT_W  measured request-to-grant latency
- lat_dropped  output  1  pulse: one or more simultaneous samples were not reported this cycle
- err_multi_grant  output  1  sticky: more than one grant bit seen high in one sample
- err_spurious  output  N_CHAN  sticky per channel: grant high while request low
- err_starve  output  N_CHAN  sticky per channel: wait reached MAX_WAIT
- grant_count  output  N_CHAN*CNT_W  flattened per-channel count of grant rising samples

Behaviour:
- Reset: all outputs 0; every channel FSM returns to IDLE; wait counters 0. Reset mid-wait discards the measurement with no report.
- Per-channel FSM, evaluated on sampled request[i]/grant[i]:
  - IDLE: req=1 & gnt=1 -> GRANTED, report latency 0. req=1 & gnt=0 -> WAIT, wait=1. Otherwise stay.
  - WAIT: gnt=1 -> GRANTED, report the current wait value. req=0 & gnt=0 -> IDLE (abandoned, no report). Otherwise wait+1, saturating at 2**LAT_W-1.
  - GRANTED: gnt=0 & req=1 -> WAIT, wait=1 (new measurement). gnt=0 & req=0 -> IDLE. Otherwise stay.
- Latency report is registered: lat_valid/lat_chan/lat_cycles appear one cycle after the grant sample.
- If several channels report in the same cycle, the lowest index wins and lat_dropped pulses with it.
- Starvation: in WAIT, when wait == MAX_WAIT with gnt still 0, set err_starve[i]. Counting continues and the later report carries the true (or saturated) value.
- err_multi_grant: set when $countones(grant) > 1 in any sample.
- err_spurious[i]: set when grant[i]=1 & request[i]=0 in any sample.
- All error flags update one cycle after the offending sample and stay sticky.
- clr_err clears all error flags. If a new error and clr_err occur in the same cycle, the set wins.
- grant_count[i] increments on each sample where grant[i] rises (previous sample 0, current sample 1). It holds at 2**CNT_W-1 and is not cleared by clr_err.

Decomposition:
- Package arb_mon_pkg: chan_state_e {IDLE, WAIT, GRANTED}; localparam CHAN_IDX_W = $clog2(N_CHAN) helper; saturating-increment function.
- Sub-module arb_mon_chan (one per channel, generate loop): FSM, wait counter, starve/spurious detect, grant counter.
- Top level: lowest-index report arbitration, multi-grant check, flattening of outputs.

Test Plan:
- N_CHAN=2: request[0] high at cycle 10, grant[0] high at cycle 13 -> lat_valid at cycle 14 with lat_chan=0, lat_cycles=3; grant_count[0]=1; no error flags.
- request[1] and grant[1] rise in the same sample -> lat_cycles=0 reported for channel 1.
- request[0] held for 20 cycles with no grant, MAX_WAIT=16 -> err_starve[0] set at the cycle after wait reaches 16; a grant at wait=20 reports lat_cycles=20; clr_err then clears err_starve[0].
- grant=2'b11 for one cycle with both requests high -> err_multi_grant set; both channels finish in the same cycle, so channel 0 is reported and lat_dropped pulses.
- grant[1] high with request[1] low -> err_spurious[1]=1. The same cycle also asserts clr_err; the flag remains set.
- rst asserted while channel 0 is in WAIT with wait=5 -> all outputs 0 immediately; after release no latency report occurs for that request until a fresh rise.
